dct_seq_ctrl: RTL and testbench

//  Parametrised phase sequencer for the 2D-DCT datapath: 1st-pass DCT, transpose load,

---
 rtl/dct_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_dct_seq_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dct_seq_ctrl
//  Description : Parametrised phase sequencer for the 2D-DCT datapath.
//                Walks ONE_DCT -> LOAD_TRANS -> UNLOAD_TRANS -> TWO_DCT with
//                configurable phase lengths. Provides a start/ready
//                handshake, a done pulse and an abort.
//                Optional feature macro: DCT_SEQ_QUEUE_EN (1-deep start queue
//                for back-to-back blocks with no IDLE bubble).
//  Revision    : 1.0 - initial release
// ============================================================================
module dct_seq_ctrl #(
    parameter int DCT_LEN    = 8,
    parameter int LOAD_LEN   = 32,
    parameter int UNLOAD_LEN = 32,
    parameter int DRAIN_LEN  = 8
) (
    input  logic       clk,
    input  logic       rst,          // asynchronous, active-low
    input  logic       start,
    input  logic       abort,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic [2:0] phase,
    output logic       load_1dct,
    output logic       load_trans,
    output logic       unload_trans,
    output logic       load_2dct
);

    // Counter must hold the largest LEN-1 of the four phases
    localparam int MAX_AB  = (DCT_LEN > LOAD_LEN) ? DCT_LEN : LOAD_LEN;
    localparam int MAX_CD  = (UNLOAD_LEN > DRAIN_LEN) ? UNLOAD_LEN : DRAIN_LEN;
    localparam int MAX_LEN = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_LEN) + 1;

    localparam logic [CNT_W-1:0] c_dct_last    = CNT_W'(DCT_LEN - 1);
    localparam logic [CNT_W-1:0] c_load_last   = CNT_W'(LOAD_LEN - 1);
    localparam logic [CNT_W-1:0] c_unload_last = CNT_W'(UNLOAD_LEN - 1);
    localparam logic [CNT_W-1:0] c_drain_last  = CNT_W'(DRAIN_LEN - 1);
    localparam logic [CNT_W-1:0] c_cnt_zero    = '0;
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ONE    = 3'd1,
        S_LOAD   = 3'd2,
        S_UNLOAD = 3'd3,
        S_TWO    = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_last;
    logic             w_accept;

`ifdef DCT_SEQ_QUEUE_EN
    logic             r_pending;
    assign ready = !r_pending;
`else
    assign ready = (r_state == S_IDLE);
`endif

    assign w_accept = start && ready;

    // Flag the final cycle of whichever phase is currently active
    always_comb begin
        w_last = 1'b0;
        case (r_state)
            S_ONE:    w_last = (r_cnt == c_dct_last);
            S_LOAD:   w_last = (r_cnt == c_load_last);
            S_UNLOAD: w_last = (r_cnt == c_unload_last);
            S_TWO:    w_last = (r_cnt == c_drain_last);
            default:  w_last = 1'b0;
        endcase
    end

    // Phase state machine, phase counter and (optional) start queue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= c_cnt_zero;
`ifdef DCT_SEQ_QUEUE_EN
            r_pending <= 1'b0;
`endif
        end else if (abort) begin
            // Abort wins over everything, including a same-cycle start
            r_state   <= S_IDLE;
            r_cnt     <= c_cnt_zero;
`ifdef DCT_SEQ_QUEUE_EN
            r_pending <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= c_cnt_zero;
                    if (w_accept) begin
                        r_state <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_last) begin
                        r_state <= S_LOAD;
                        r_cnt   <= c_cnt_zero;
                    end else begin
                        r_cnt   <= r_cnt + c_cnt_one;
                    end
                end
                S_LOAD: begin
                    if (w_last) begin
                        r_state <= S_UNLOAD;
                        r_cnt   <= c_cnt_zero;
                    end else begin
                        r_cnt   <= r_cnt + c_cnt_one;
                    end
                end
                S_UNLOAD: begin
                    if (w_last) begin
                        r_state <= S_TWO;
                        r_cnt   <= c_cnt_zero;
                    end else begin
                        r_cnt   <= r_cnt + c_cnt_one;
                    end
                end
                S_TWO: begin
                    if (w_last) begin
                        r_cnt <= c_cnt_zero;
`ifdef DCT_SEQ_QUEUE_EN
                        // A queued or same-cycle start chains straight into the next block
                        if (r_pending || w_accept) begin
                            r_state   <= S_ONE;
                            r_pending <= 1'b0;
                        end else begin
                            r_state   <= S_IDLE;
                        end
`else
                        r_state <= S_IDLE;
`endif
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    // Illegal encodings recover to IDLE
                    r_state <= S_IDLE;
                    r_cnt   <= c_cnt_zero;
`ifdef DCT_SEQ_QUEUE_EN
                    r_pending <= 1'b0;
`endif
                end
            endcase
`ifdef DCT_SEQ_QUEUE_EN
            // Capture a start that arrives while a block is running
            if (w_accept && ((r_state == S_ONE) || (r_state == S_LOAD) ||
                             (r_state == S_UNLOAD) || ((r_state == S_TWO) && !w_last))) begin
                r_pending <= 1'b1;
            end
`endif
        end
    end

    assign phase        = r_state;
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_TWO) && (r_cnt == c_drain_last);
    assign load_1dct    = (r_state == S_ONE) || (r_state == S_LOAD);
    assign load_trans   = (r_state == S_LOAD);
    assign unload_trans = (r_state == S_UNLOAD);
    assign load_2dct    = (r_state == S_UNLOAD) || (r_state == S_TWO);

endmodule
`default_nettype wire

// File: tb/tb_dct_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dct_seq_ctrl
//  Description : Directed self-checking bench for dct_seq_ctrl. One instance
//                with default phase lengths, one with 2/3/3/1.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dct_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start, abort;
    logic       ready, busy, done;
    logic [2:0] phase;
    logic       load_1dct, load_trans, unload_trans, load_2dct;

    logic       start_b, abort_b;
    logic       ready_b, busy_b, done_b;
    logic [2:0] phase_b;
    logic       load_1dct_b, load_trans_b, unload_trans_b, load_2dct_b;

    int errors = 0;
    int checks = 0;

    dct_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ready(ready), .busy(busy), .done(done), .phase(phase),
        .load_1dct(load_1dct), .load_trans(load_trans),
        .unload_trans(unload_trans), .load_2dct(load_2dct)
    );

    dct_seq_ctrl #(.DCT_LEN(2), .LOAD_LEN(3), .UNLOAD_LEN(3), .DRAIN_LEN(1)) dut_small (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .ready(ready_b), .busy(busy_b), .done(done_b), .phase(phase_b),
        .load_1dct(load_1dct_b), .load_trans(load_trans_b),
        .unload_trans(unload_trans_b), .load_2dct(load_2dct_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock, land 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Reset asserted from time zero: outputs must already be in reset state
        checks++;
        if ({phase, busy, ready, done, load_1dct, load_trans, unload_trans, load_2dct} !== {3'd0, 1'b0, 1'b1, 5'b0}) begin
            errors++;
            $display("FAIL reset_state: got phase=%0d busy=%b ready=%b done=%b l1=%b lt=%b ut=%b l2=%b, want 0/0/1/0/0/0/0/0",
                     phase, busy, ready, done, load_1dct, load_trans, unload_trans, load_2dct);
        end
        tick(); tick();
        rst = 1'b1;
        tick();
        // Start a block and get into LOAD_TRANS (cycle 10 = LOAD cnt 1)
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        checks++;
        if (load_trans !== 1'b1 || phase !== 3'd2) begin
            errors++;
            $display("FAIL reset_pre_load: got phase=%0d load_trans=%b, want 2/1", phase, load_trans);
        end
        // Asynchronous reset mid-cycle
        #2 rst = 1'b0;
        #1;
        checks++;
        if (phase !== 3'd0 || busy !== 1'b0 || ready !== 1'b1 || load_trans !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got phase=%0d busy=%b ready=%b lt=%b, want 0/0/1/0", phase, busy, ready, load_trans);
        end
        #3 rst = 1'b1;
        begin
            int dcnt = 0;
            int busy_cnt = 0;
            for (int c = 0; c < 100; c++) begin
                tick();
                if (done === 1'b1) dcnt++;
                if (busy !== 1'b0) busy_cnt++;
            end
            checks++;
            if (dcnt !== 0 || busy_cnt !== 0) begin
                errors++;
                $display("FAIL reset_no_done: got done=%0d busy_cycles=%0d, want 0/0", dcnt, busy_cnt);
            end
        end
    endtask

    task automatic test_default_block();
        int dcnt = 0, dcyc = 0, l1 = 0, l2 = 0, lt = 0, ut = 0, perr = 0;
        logic [2:0] exp_ph;
        start = 1'b1;
        tick();                      // edge E0
        start = 1'b0;
        checks++;
`ifdef DCT_SEQ_QUEUE_EN
        if (ready !== 1'b1) begin
`else
        if (ready !== 1'b0) begin
`endif
            errors++;
            $display("FAIL default_ready_busy: got ready=%b", ready);
        end
        for (int c = 1; c <= 80; c++) begin
            exp_ph = (c <= 8) ? 3'd1 : (c <= 40) ? 3'd2 : (c <= 72) ? 3'd3 : 3'd4;
            if (phase !== exp_ph) begin
                perr++;
                if (perr < 4) $display("FAIL default_phase: cycle %0d got %0d want %0d", c, phase, exp_ph);
            end
            if (done === 1'b1) begin dcnt++; dcyc = c; end
            if (load_1dct === 1'b1) l1++;
            if (load_2dct === 1'b1) l2++;
            if (load_trans === 1'b1) lt++;
            if (unload_trans === 1'b1) ut++;
            tick();
        end
        checks++;
        if (perr !== 0) begin
            errors++;
            $display("FAIL default_phase_seq: got %0d wrong cycles, want 0", perr);
        end
        checks++;
        if (dcnt !== 1 || dcyc !== 80) begin
            errors++;
            $display("FAIL default_done: got %0d pulses at cycle %0d, want 1 at 80", dcnt, dcyc);
        end
        checks++;
        if (l1 !== 40 || l2 !== 40 || lt !== 32 || ut !== 32) begin
            errors++;
            $display("FAIL default_enables: got l1=%0d l2=%0d lt=%0d ut=%0d, want 40/40/32/32", l1, l2, lt, ut);
        end
        checks++;
        if (phase !== 3'd0 || busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL default_return_idle: got phase=%0d busy=%b ready=%b done=%b, want 0/0/1/0", phase, busy, ready, done);
        end
    endtask

    task automatic test_small_params();
        logic [2:0] exp_seq [10] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
        int perr = 0, dcyc = 0, dcnt = 0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (phase_b !== exp_seq[c-1]) begin
                perr++;
                $display("FAIL small_phase: cycle %0d got %0d want %0d", c, phase_b, exp_seq[c-1]);
            end
            if (done_b === 1'b1) begin dcnt++; dcyc = c; end
            tick();
        end
        checks++;
        if (perr !== 0) begin
            errors++;
            $display("FAIL small_phase_seq: got %0d wrong cycles, want 0", perr);
        end
        checks++;
        if (dcnt !== 1 || dcyc !== 9) begin
            errors++;
            $display("FAIL small_done: got %0d pulses at cycle %0d, want 1 at 9", dcnt, dcyc);
        end
    endtask

    task automatic test_abort();
        int dcnt = 0, bcnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 46; c++) begin
            if (done === 1'b1) dcnt++;
            tick();
        end
        // Cycle 46 = UNLOAD_TRANS cnt 5
        checks++;
        if (phase !== 3'd3 || unload_trans !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: got phase=%0d ut=%b, want 3/1", phase, unload_trans);
        end
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        checks++;
        if (phase !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle: got phase=%0d busy=%b done=%b ready=%b, want 0/0/0/1", phase, busy, done, ready);
        end
        for (int c = 0; c < 50; c++) begin
            if (done === 1'b1) dcnt++;
            if (busy !== 1'b0) bcnt++;
            tick();
        end
        checks++;
        if (dcnt !== 0 || bcnt !== 0) begin
            errors++;
            $display("FAIL abort_quiet: got done=%0d busy_cycles=%0d, want 0/0", dcnt, bcnt);
        end
    endtask

`ifndef DCT_SEQ_QUEUE_EN
    task automatic test_back_to_back();
        start = 1'b1;                // held throughout block A
        tick();                      // E0
        for (int c = 1; c < 20; c++) tick();
        checks++;
        if (ready !== 1'b0 || phase !== 3'd2) begin
            errors++;
            $display("FAIL b2b_ready_low: got ready=%b phase=%0d, want 0/2", ready, phase);
        end
        for (int c = 20; c < 80; c++) tick();
        checks++;
        if (done !== 1'b1 || phase !== 3'd4) begin
            errors++;
            $display("FAIL b2b_done_a: got done=%b phase=%0d, want 1/4", done, phase);
        end
        tick();
        checks++;
        if (phase !== 3'd0 || ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap: got phase=%0d ready=%b busy=%b, want 0/1/0", phase, ready, busy);
        end
        tick();
        start = 1'b0;
        checks++;
        if (phase !== 3'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept_b: got phase=%0d busy=%b, want 1/1", phase, busy);
        end
        for (int c = 1; c < 80; c++) tick();
        checks++;
        if (done !== 1'b1 || phase !== 3'd4) begin
            errors++;
            $display("FAIL b2b_done_b: got done=%b phase=%0d, want 1/4", done, phase);
        end
        tick();
        checks++;
        if (phase !== 3'd0) begin
            errors++;
            $display("FAIL b2b_end_idle: got phase=%0d, want 0", phase);
        end
    endtask
`else
    task automatic test_back_to_back();
        int dcnt = 0;
        start = 1'b1;
        tick();                      // E0
        start = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL queue_ready_before: got ready=%b, want 1", ready);
        end
        start = 1'b1;                // cycle 20: queued
        tick();
        start = 1'b0;
        checks++;
        if (ready !== 1'b0 || phase !== 3'd2) begin
            errors++;
            $display("FAIL queue_ready_drop: got ready=%b phase=%0d, want 0/2", ready, phase);
        end
        for (int c = 21; c < 80; c++) tick();
        checks++;
        if (done !== 1'b1 || phase !== 3'd4) begin
            errors++;
            $display("FAIL queue_done_a: got done=%b phase=%0d, want 1/4", done, phase);
        end
        tick();
        checks++;
        if (phase !== 3'd1 || ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL queue_no_bubble: got phase=%0d ready=%b done=%b, want 1/1/0", phase, ready, done);
        end
        for (int c = 1; c < 80; c++) begin
            if (done === 1'b1) dcnt++;
            tick();
        end
        checks++;
        if (done !== 1'b1 || dcnt !== 0) begin
            errors++;
            $display("FAIL queue_done_b: got done=%b early_pulses=%0d, want 1/0", done, dcnt);
        end
        tick();
        checks++;
        if (phase !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL queue_end_idle: got phase=%0d busy=%b, want 0/0", phase, busy);
        end
    endtask
`endif

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        start_b = 1'b0;
        abort_b = 1'b0;
        #1;
        test_reset();
        test_default_block();
        test_small_params();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
